dp_exec_ctrl: RTL
=================

# dp_exec_ctrl

Sequencer for the ARM data-processing ALU. It accepts one decoded data-processing instruction at a time, together with its already-fetched operands. It evaluates the condition field against the CPSR flag register it owns, then drives the combinational ALU. Finally it writes back the result and, when S=1, updates the flags. It sits between operand fetch and the register-file write port.

## Interface

**Parameters**
- none

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: an instruction and its operands are presented.
- `instr_ready` out 1: high only in IDLE; an instruction is accepted when `instr_valid && instr_ready`.
- `instr` in 32: instruction word. Fields: [31:28] cond, [27:26] class, [24:21] opcode, [20] S, [19:16] Rn, [15:12] Rd.
- `op_a` in 32: Rn value, sampled on accept.
- `op_b` in 32: barrel-shifter output, sampled on accept.
- `shift_carry` in 1: shifter carry-out, sampled on accept.
- `flush` in 1: abort the in-flight instruction.
- `alu_opcode` out 4: latched opcode.
- `alu_a` out 32: latched `op_a`.
- `alu_b` out 32: latched `op_b`.
- `alu_carry_in` out 1: `flags[1]`.
- `alu_result` in 32: ALU result.
- `alu_nzvc` in 4: ALU flags, ordered {N,Z,V,C}.
- `wb_en` out 1: register write strobe, one cycle.
- `wb_addr` out 4: destination register Rd.
- `wb_data` out 32: write-back data.
- `pc_write` out 1: pulses with `wb_en` when Rd=15.
- `flags` out 4: CPSR flags, ordered {N,Z,C,V}.
- `done` out 1: one-cycle pulse per retired, skipped or illegal instruction.
- `illegal` out 1: pulses with `done` when `instr[27:26] != 2'b00`.

## Operation

**States**

IDLE → COND → EXEC → WB → IDLE.
- IDLE:
  - `instr_ready=1`.
  - On accept, latch `instr`, `op_a`, `op_b` and `shift_carry`; go to COND.
- COND: evaluate cond against `flags`.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 never.
  - Class != 00: pulse `done` and `illegal`, go to IDLE.
  - Condition fails: pulse `done`, go to IDLE; no write-back, flags unchanged.
  - Otherwise go to EXEC.
- EXEC:
  - ALU inputs are always driven from the latched registers.
  - Capture `alu_result` and `alu_nzvc` into internal registers at the end of the cycle; go to WB.
- WB:
  - `wb_en=1` unless opcode ∈ {TST, TEQ, CMP, CMN} (1000–1011).
  - `wb_addr` = Rd, `wb_data` = captured result.
  - `pc_write` = `wb_en && Rd==15`.
  - `done=1`.
  - If S=1, update `flags` at the end of the cycle:
    - Arithmetic opcodes (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN): {N,Z,C,V} = {nzvc[3], nzvc[2], nzvc[0], nzvc[1]}.
    - Logical opcodes (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): N and Z from the ALU, C = latched `shift_carry`, V unchanged.
  - Go to IDLE.

**Flush**
- `flush` in COND, EXEC or WB: go to IDLE next edge.
- Outputs are already gated in that cycle: `wb_en`, `pc_write` and `done` are forced to 0, and flags are not updated.
- `flush` in IDLE has no effect; an accept in the same cycle is still taken.

**Reset**
- Asynchronous; applies mid-operation. State returns to IDLE and the latched instruction is discarded.
- Output reset values: `flags=0`, `instr_ready=1`, `wb_en=0`, `pc_write=0`, `done=0`, `illegal=0`, `wb_addr=0`, `wb_data=0`, `alu_opcode=0`, `alu_a=0`, `alu_b=0`.

## Timing

- Accept at edge T. COND runs in cycle T..T+1, EXEC in T+1..T+2, WB in T+2..T+3.
- `instr_ready` is next high in cycle T+3..T+4.
- A retired instruction takes 4 cycles per instruction.
- A skipped or illegal instruction takes 2 cycles; `done` is asserted in its COND cycle.
- New flags are visible from edge T+3. A back-to-back conditional instruction therefore sees them, because its COND cycle is no earlier than T+4.
- `wb_en`, `pc_write`, `done` and `illegal` are never high for more than one cycle.

## Test plan

1. **ADDS overflow.** Reset, then `instr=0xE0921000` (ADDS r1,r2), `op_a=0x7FFFFFFF`, `op_b=1`. Expect in the WB cycle `wb_en=1`, `wb_addr=1`, `wb_data=0x80000000`; afterwards `flags=4'b1001`.
2. **CMP equal.** `instr=0xE1520000`, `op_a=5`, `op_b=5`. Expect `wb_en` never asserted, `done` once, `flags=4'b0110`.
3. **Condition fail.** With Z=1, `instr=0x11A03000` (MOVNE r3). Expect `done` in the COND cycle, no `wb_en`, flags unchanged, `instr_ready` high 2 cycles after accept.
4. **Logical flags.** With `flags=4'b0001`, ANDS `0xE0110002`, `op_a=0xF0`, `op_b=0x0F`, `shift_carry=1`. Expect `wb_data=0`, `flags=4'b0111`.
5. **Flush and reset.** Assert `flush` in EXEC of test 1: expect no `wb_en`, no `done`, flags unchanged, IDLE next cycle. Deassert `rst_n` in WB: expect all outputs at reset values immediately, including `flags=0`.
6. **PC write and illegal.** MOV pc `0xE1A0F000`, `op_b=0x100`: expect `wb_en=1`, `pc_write=1`, `wb_data=0x100`. Then `instr=0xEA000000`: expect `done=1`, `illegal=1`, no `wb_en`.

Source files
------------

// File: rtl/dp_exec_ctrl_if.sv
// dp_exec_ctrl bus: instruction handshake, ALU port,
// write-back port and status.
interface dp_exec_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        shift_carry;
  logic        flush;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_carry_in;
  logic [31:0] alu_result;
  logic [3:0]  alu_nzvc;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_write;
  logic [3:0]  flags;
  logic        done;
  logic        illegal;

  modport master (
    output instr_valid, instr, op_a, op_b,
    output shift_carry, flush,
    output alu_result, alu_nzvc,
    input  instr_ready, alu_opcode, alu_a, alu_b,
    input  alu_carry_in, wb_en, wb_addr, wb_data,
    input  pc_write, flags, done, illegal
  );

  modport slave (
    input  instr_valid, instr, op_a, op_b,
    input  shift_carry, flush,
    input  alu_result, alu_nzvc,
    output instr_ready, alu_opcode, alu_a, alu_b,
    output alu_carry_in, wb_en, wb_addr, wb_data,
    output pc_write, flags, done, illegal
  );
endinterface

// File: rtl/dp_exec_ctrl.sv
// ARM data-processing sequencer: condition check,
// ALU drive, write-back and CPSR flag ownership.
module dp_exec_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  dp_exec_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COND,
    S_EXEC,
    S_WB
  } state_e;

  state_e      state_q;
  logic [3:0]  cond_q;
  logic [1:0]  cls_q;
  logic [3:0]  opc_q;
  logic        s_q;
  logic [3:0]  rd_q;
  logic        sc_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic [3:0]  nzvc_q;
  logic [3:0]  flags_q;
  logic [3:0]  flags_d;

  logic fn, fz, fc, fv;
  logic cond_ok;
  logic bad_cls;
  logic is_cmp;
  logic is_arith;
  logic in_cond;
  logic in_wb;
  logic live;
  logic unused_bits;

  assign fn = flags_q[3];
  assign fz = flags_q[2];
  assign fc = flags_q[1];
  assign fv = flags_q[0];

  assign bad_cls = (cls_q != 2'b00);
  assign is_cmp  = (opc_q[3:2] == 2'b10);
  assign is_arith = (opc_q[3:2] == 2'b01)
                 || (opc_q[3:1] == 3'b001)
                 || (opc_q[3:1] == 3'b101);

  assign in_cond = (state_q == S_COND);
  assign in_wb   = (state_q == S_WB);
  assign live    = !bus.flush;

  assign unused_bits = ^{bus.instr[25],
                         bus.instr[19:16],
                         bus.instr[11:0]};

  // Condition field evaluated against the current flags
  always_comb begin
    cond_ok = 1'b0;
    unique case (cond_q)
      4'h0: cond_ok = fz;
      4'h1: cond_ok = !fz;
      4'h2: cond_ok = fc;
      4'h3: cond_ok = !fc;
      4'h4: cond_ok = fn;
      4'h5: cond_ok = !fn;
      4'h6: cond_ok = fv;
      4'h7: cond_ok = !fv;
      4'h8: cond_ok = fc && !fz;
      4'h9: cond_ok = !fc || fz;
      4'hA: cond_ok = (fn == fv);
      4'hB: cond_ok = (fn != fv);
      4'hC: cond_ok = !fz && (fn == fv);
      4'hD: cond_ok = fz || (fn != fv);
      4'hE: cond_ok = 1'b1;
      4'hF: cond_ok = 1'b0;
    endcase
  end

  assign bus.instr_ready  = (state_q == S_IDLE);
  assign bus.alu_opcode   = opc_q;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_carry_in = fc;
  assign bus.wb_addr      = rd_q;
  assign bus.wb_data      = res_q;
  assign bus.flags        = flags_q;

  assign bus.illegal = in_cond && bad_cls && live;
  assign bus.done    = live
                    && ((in_cond && (bad_cls || !cond_ok))
                     || in_wb);
  assign bus.wb_en    = in_wb && live && !is_cmp;
  assign bus.pc_write = bus.wb_en && (rd_q == 4'hF);

  // Flag update at the end of an unflushed WB with S set
  always_comb begin
    flags_d = flags_q;
    if (in_wb && live && s_q) begin
      if (is_arith) begin
        flags_d = {nzvc_q[3], nzvc_q[2],
                   nzvc_q[0], nzvc_q[1]};
      end else begin
        flags_d = {nzvc_q[3], nzvc_q[2],
                   sc_q, flags_q[0]};
      end
    end
  end

  // CPSR flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'h0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Sequencer: accept, condition, execute, write back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cond_q  <= 4'h0;
      cls_q   <= 2'b00;
      opc_q   <= 4'h0;
      s_q     <= 1'b0;
      rd_q    <= 4'h0;
      sc_q    <= 1'b0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      res_q   <= 32'h0;
      nzvc_q  <= 4'h0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.instr_valid) begin
            cond_q  <= bus.instr[31:28];
            cls_q   <= bus.instr[27:26];
            opc_q   <= bus.instr[24:21];
            s_q     <= bus.instr[20];
            rd_q    <= bus.instr[15:12];
            sc_q    <= bus.shift_carry;
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            state_q <= S_COND;
          end
        end
        S_COND: begin
          if (!live || bad_cls || !cond_ok) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q   <= bus.alu_result;
          nzvc_q  <= bus.alu_nzvc;
          state_q <= live ? S_WB : S_IDLE;
        end
        S_WB: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
